// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: control and status bundle for one sr_ff_bank instance.
//   en, s, r          per-channel enable / set request / reset request
//   sync_clr          synchronous load of the reset value into every channel
//   conflict_clr      clears the conflict sticky flags and counter
//   q                 stored channel state
//   rise, fall        one-cycle edge pulses aligned with q
//   conflict_sticky   per-channel latched S=R=1 flag
//   conflict_cnt      saturating count of cycles with any conflict
// master drives the requests and observes status; slave is the bank.
interface sr_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             sync_clr;
    logic             conflict_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output en, s, r, sync_clr, conflict_clr,
        input  q, rise, fall, conflict_sticky, conflict_cnt
    );

    modport slave (
        input  en, s, r, sync_clr, conflict_clr,
        output q, rise, fall, conflict_sticky, conflict_cnt
    );
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH independent set/reset flag bits with per-channel enable,
// a defined S=R=1 resolution (MODE), synchronous clear, registered edge
// pulses and conflict monitoring (sticky flags plus saturating counter).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (q=RESET_VAL, all status 0)
//   bus      sr_ff_bank_if.slave; its WIDTH/CNT_W must match this module's
// MODE: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input logic         clk,
    input logic         reset_n,
    sr_ff_bank_if.slave bus
);

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_ff_bank: CNT_W must be 2..16");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] sticky_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] cf;
    logic [WIDTH-1:0] sticky_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        nq = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.sync_clr) begin
                nq[i] = RESET_VAL[i];
            end else if (bus.en[i]) begin
                case ({bus.s[i], bus.r[i]})
                    2'b01:   nq[i] = 1'b0;
                    2'b10:   nq[i] = 1'b1;
                    2'b11: begin
                        if (MODE == 1)      nq[i] = 1'b1;
                        else if (MODE == 2) nq[i] = 1'b0;
                        else if (MODE == 3) nq[i] = ~q_r[i];
                        else                nq[i] = q_r[i];
                    end
                    default: nq[i] = q_r[i];
                endcase
            end
        end
    end

    // A conflict is counted in every MODE, but a sync_clr cycle masks it
    // because the request was never acted on.
    assign cf = bus.en & bus.s & bus.r & {WIDTH{~bus.sync_clr}};

    // New conflicts win over a simultaneous clear.
    assign sticky_nxt = cf | (sticky_r & ~{WIDTH{bus.conflict_clr}});

    always_comb begin
        cnt_nxt = cnt_r;
        if (bus.conflict_clr) begin
            cnt_nxt = (|cf) ? CNT_W'(1) : '0;
        end else if ((|cf) && (cnt_r != CNT_MAX)) begin
            cnt_nxt = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r      <= RESET_VAL;
            rise_r   <= '0;
            fall_r   <= '0;
            sticky_r <= '0;
            cnt_r    <= '0;
        end else begin
            q_r      <= nq;
            rise_r   <= nq & ~q_r;
            fall_r   <= ~nq & q_r;
            sticky_r <= sticky_nxt;
            cnt_r    <= cnt_nxt;
        end
    end

    assign bus.q               = q_r;
    assign bus.rise            = rise_r;
    assign bus.fall            = fall_r;
    assign bus.conflict_sticky = sticky_r;
    assign bus.conflict_cnt    = cnt_r;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: five instances share one stimulus.
//   dut0..dut3: MODE 0..3, CNT_W 8; dut4: MODE 0, CNT_W 2 (saturation).
// Stimulus pushes hand-computed expectations tagged with the cycle they are
// due; a monitor pops and compares them on the falling clock edge, or at
// once when the stimulus signals an out-of-edge sample (async reset).
module tb_sr_ff_bank;

    localparam int N = 5;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] sticky;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] en, s, r;
    logic       sync_clr, conflict_clr;

    logic [7:0] q_a      [N];
    logic [7:0] rise_a   [N];
    logic [7:0] fall_a   [N];
    logic [7:0] sticky_a [N];
    logic [7:0] cnt_a    [N];

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    event sample_now;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_ff_bank_if #(.WIDTH(8), .CNT_W((g == 4) ? 2 : 8)) bus ();
        assign bus.en           = en;
        assign bus.s            = s;
        assign bus.r            = r;
        assign bus.sync_clr     = sync_clr;
        assign bus.conflict_clr = conflict_clr;

        sr_ff_bank #(
            .WIDTH(8),
            .MODE((g == 4) ? 0 : g),
            .RESET_VAL(RV),
            .CNT_W((g == 4) ? 2 : 8)
        ) dut (
            .clk(clk),
            .reset_n(reset_n),
            .bus(bus)
        );

        assign q_a[g]      = bus.q;
        assign rise_a[g]   = bus.rise;
        assign fall_a[g]   = bus.fall;
        assign sticky_a[g] = bus.conflict_sticky;
        assign cnt_a[g]    = 8'(bus.conflict_cnt);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string tag, int idx, string fld, logic [7:0] got, logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d %s got %h expected %h", tag, idx, fld, got, want);
        end
    endtask

    // Monitor: checks every expectation whose due cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                cmp(e.tag, e.idx, "q",      q_a[e.idx],      e.q);
                cmp(e.tag, e.idx, "rise",   rise_a[e.idx],   e.rise);
                cmp(e.tag, e.idx, "fall",   fall_a[e.idx],   e.fall);
                cmp(e.tag, e.idx, "sticky", sticky_a[e.idx], e.sticky);
                cmp(e.tag, e.idx, "cnt",    cnt_a[e.idx],    e.cnt);
            end
        end
    end

    task automatic push(int due, int idx, logic [7:0] eq, logic [7:0] er, logic [7:0] ef,
                        logic [7:0] es, logic [7:0] ec, string tag);
        exp_t e;
        e.due = due; e.idx = idx; e.q = eq; e.rise = er; e.fall = ef;
        e.sticky = es; e.cnt = ec; e.tag = tag;
        sb.push_back(e);
    endtask

    // Expectation for the state after the coming clock edge.
    task automatic expn(int idx, logic [7:0] eq, logic [7:0] er, logic [7:0] ef,
                        logic [7:0] es, logic [7:0] ec, string tag);
        push(cyc + 1, idx, eq, er, ef, es, ec, tag);
    endtask

    task automatic expn_all(logic [7:0] eq, logic [7:0] er, logic [7:0] ef,
                            logic [7:0] es, logic [7:0] ec, string tag);
        for (int i = 0; i < N; i++) expn(i, eq, er, ef, es, ec, tag);
    endtask

    task automatic drive(logic [7:0] ev, logic [7:0] sv, logic [7:0] rv, logic sc, logic cc);
        en = ev; s = sv; r = rv; sync_clr = sc; conflict_clr = cc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) push(cyc, i, RV, 8'h00, 8'h00, 8'h00, 8'h00, "in_reset");
        -> sample_now;
        #1;
        reset_n = 1'b1;

        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        expn_all(RV, 8'h00, 8'h00, 8'h00, 8'h00, "release");
        tick();

        drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        expn_all(8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, "reset_all");
        tick();

        drive(8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0);
        expn_all(8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, "set_lo");
        tick();

        drive(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
        expn_all(8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "pulse_end");
        tick();

        // Sustained S=R=1 on bit0 for six cycles starting from q0=1.
        for (int k = 1; k <= 6; k++) begin
            drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
            expn(0, 8'h0F, 8'h00, 8'h00, 8'h01, 8'(k), "conflict_hold");
            expn(1, 8'h0F, 8'h00, 8'h00, 8'h01, 8'(k), "conflict_set");
            expn(2, 8'h0E, 8'h00, (k == 1) ? 8'h01 : 8'h00, 8'h01, 8'(k), "conflict_rst");
            expn(3, (k % 2) ? 8'h0E : 8'h0F, (k % 2) ? 8'h00 : 8'h01,
                 (k % 2) ? 8'h01 : 8'h00, 8'h01, 8'(k), "conflict_tog");
            expn(4, 8'h0F, 8'h00, 8'h00, 8'h01, (k > 3) ? 8'd3 : 8'(k), "cnt_sat");
            tick();
        end

        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        expn(0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "cclr");
        expn(1, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "cclr");
        expn(2, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, "cclr");
        expn(3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "cclr");
        expn(4, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "cclr");
        tick();

        drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b1);
        expn(0, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h01, "cclr_with_cf");
        expn(1, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h01, "cclr_with_cf");
        expn(2, 8'h0E, 8'h00, 8'h00, 8'h01, 8'h01, "cclr_with_cf");
        expn(3, 8'h0E, 8'h00, 8'h01, 8'h01, 8'h01, "cclr_with_cf");
        expn(4, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h01, "cclr_with_cf");
        tick();

        drive(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        expn(0, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, "set_all");
        expn(1, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, "set_all");
        expn(2, 8'hFF, 8'hF1, 8'h00, 8'h00, 8'h00, "set_all");
        expn(3, 8'hFF, 8'hF1, 8'h00, 8'h00, 8'h00, "set_all");
        expn(4, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, "set_all");
        tick();

        drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
        expn_all(RV, 8'h00, 8'h5A, 8'h00, 8'h00, "sync_clr");
        tick();

        drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        expn(0, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, "pre_rst");
        expn(1, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, "pre_rst");
        expn(2, 8'hA4, 8'h00, 8'h01, 8'h01, 8'h01, "pre_rst");
        expn(3, 8'hA4, 8'h00, 8'h01, 8'h01, 8'h01, "pre_rst");
        expn(4, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, "pre_rst");
        tick();

        // Pulse reset between edges while dut3 is mid-toggle.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) push(cyc, i, RV, 8'h00, 8'h00, 8'h00, 8'h00, "async_rst");
        -> sample_now;
        #1;
        reset_n = 1'b1;

        expn(0, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, "resume1");
        expn(3, 8'hA4, 8'h00, 8'h01, 8'h01, 8'h01, "resume1");
        tick();
        expn(0, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, "resume2");
        expn(3, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, "resume2");
        tick();

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
